// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for a Sobel stage: two line buffers plus short
// per-row tap registers turn a raster pixel stream into interior-centre windows.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PIX_W-1:0]     in_pixel,
  output logic                 out_valid,
  output logic [9*PIX_W-1:0]   out_window,
  output logic [CNT_W-1:0]     out_row,
  output logic [CNT_W-1:0]     out_col,
  output logic                 frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] r_q, r_d, c_q, c_d;
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  // Index 0 holds column c-1, index 1 holds column c-2; column c comes straight from the buffers.
  logic [PIX_W-1:0] top_q [2];
  logic [PIX_W-1:0] mid_q [2];
  logic [PIX_W-1:0] bot_q [2];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [AW-1:0]    idx;
  logic             last_col, last_pix, emit, frame_end;
  logic             out_valid_q, frame_done_q;
  logic [9*PIX_W-1:0] out_window_q;
  logic [CNT_W-1:0] out_row_q, out_col_q;

  assign idx      = c_q[AW-1:0];
  assign lb1_rd   = lb1_q[idx];
  assign lb2_rd   = lb2_q[idx];
  assign last_col = (c_q == CNT_W'(IMG_W - 1));
  assign last_pix = last_col && (r_q == CNT_W'(IMG_H - 1));

  // Raster position of the next pixel to be accepted.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (in_valid) begin
      if (last_col) begin
        c_d = '0;
        r_d = last_pix ? '0 : r_q + CNT_W'(1);
      end else begin
        c_d = c_q + CNT_W'(1);
      end
    end else begin
      r_d = r_q;
    end
  end

  // Next-state logic: FILL covers rows 0 and 1, RUN the rows that can emit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = FILL;
        else          state_d = IDLE;
      end
      FILL: begin
        if (in_valid && last_col && (r_q == CNT_W'(1))) state_d = RUN;
        else                                           state_d = FILL;
      end
      RUN: begin
        if (in_valid && last_pix) state_d = IDLE;
        else                      state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: columns 0 and 1 never emit, so windows never straddle rows.
  always_comb begin
    emit      = 1'b0;
    frame_end = 1'b0;
    if (in_valid && (state_q == RUN) && (c_q >= CNT_W'(2))) begin
      emit      = 1'b1;
      frame_end = last_pix;
    end else begin
      emit      = 1'b0;
      frame_end = 1'b0;
    end
  end

  // State, counters, tap registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      r_q          <= '0;
      c_q          <= '0;
      top_q        <= '{default: '0};
      mid_q        <= '{default: '0};
      bot_q        <= '{default: '0};
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      out_valid_q  <= emit;
      frame_done_q <= frame_end;
      if (in_valid) begin
        top_q[1] <= top_q[0];
        top_q[0] <= lb2_rd;
        mid_q[1] <= mid_q[0];
        mid_q[0] <= lb1_rd;
        bot_q[1] <= bot_q[0];
        bot_q[0] <= in_pixel;
      end
      if (emit) begin
        out_window_q <= {in_pixel, bot_q[0], bot_q[1],
                         lb1_rd,   mid_q[0], mid_q[1],
                         lb2_rd,   top_q[0], top_q[1]};
        out_row_q    <= r_q - CNT_W'(1);
        out_col_q    <= c_q - CNT_W'(1);
      end
    end
  end

  // Line buffers are read before write and are deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2_q[idx] <= lb1_rd;
      lb1_q[idx] <= in_pixel;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: the driver pushes expected windows from a
// ramp-image model, and a negedge monitor pops and compares each DUT window.
module tb_sobel_window_gen;
  localparam int W = 64;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic [71:0] out_window;
  logic [6:0]  out_row;
  logic [6:0]  out_col;
  logic        frame_done;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_window(out_window), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [71:0] win;
    logic [6:0]  row;
    logic [6:0]  col;
    logic        fd;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   n_fd     = 0;
  int   br = 0;
  int   bc = 0;
  bit   cap_arm = 1'b0;
  bit   cap_done = 1'b0;
  logic [71:0] cap_win;
  logic [6:0]  cap_row, cap_col;
  logic [71:0] last_win;
  logic [6:0]  last_row, last_col;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input bit inv);
    logic [7:0] v;
    v = 8'((r * 64 + c) & 255);
    return inv ? 8'(8'd255 - v) : v;
  endfunction

  task automatic send_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_pixel = 8'($urandom_range(0, 255));
  endtask

  task automatic send_valid(input bit inv);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_pixel = pix(br, bc, inv);
    if (br >= 2 && bc >= 2) begin
      for (int k = 0; k < 9; k++)
        e.win[k*8 +: 8] = pix(br - 2 + k / 3, bc - 2 + k % 3, inv);
      e.row = 7'(br - 1);
      e.col = 7'(bc - 1);
      e.fd  = (br == H - 1) && (bc == W - 1);
      e.due = cyc + 1;
      q.push_back(e);
    end
    if (bc == W - 1) begin
      bc = 0;
      br = (br == H - 1) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
  endtask

  task automatic run_pixels(input int n, input bit inv, input bit rnd, input bit arm);
    int sent;
    sent = 0;
    while (sent < n) begin
      if (rnd && $urandom_range(0, 1) == 0) begin
        send_idle();
      end else begin
        send_valid(inv);
        sent++;
        if (arm && sent == 2) begin
          cap_done = 1'b0;
          cap_arm  = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    repeat (3) send_idle();
    chk("queue_empty", q.size(), 0);
  endtask

  // Monitor: pop and compare on every out_valid, flag late or spurious windows.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      n_valid++;
      if (frame_done) begin
        n_fd++;
        last_win = out_window;
        last_row = out_row;
        last_col = out_col;
      end
      if (cap_arm && !cap_done) begin
        cap_win  = out_window;
        cap_row  = out_row;
        cap_col  = out_col;
        cap_done = 1'b1;
        cap_arm  = 1'b0;
      end
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got window row %0d col %0d, expected none (cycle %0d)",
                 out_row, out_col, cyc);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("window", out_window, e.win);
        chk("row", out_row, e.row);
        chk("col", out_col, e.col);
        chk("frame_done", frame_done, e.fd);
      end
    end else begin
      chk("frame_done_idle", frame_done, 1'b0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid: got none, expected row %0d col %0d (cycle %0d)",
                 q[0].row, q[0].col, cyc);
        void'(q.pop_front());
      end
    end
  end

  int v0, f0;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = 8'h00;

    // Reset held 3 cycles with in_valid toggling.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = (i % 2 == 0);
      in_pixel = 8'hAA;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_window", out_window, 72'h0);
    chk("rst_row", out_row, 7'd0);
    chk("rst_col", out_col, 7'd0);
    chk("rst_fd", frame_done, 1'b0);

    // Continuous ramp frame.
    v0 = n_valid; f0 = n_fd;
    run_pixels(W * H, 1'b0, 1'b0, 1'b1);
    drain();
    chk("s2_count", n_valid - v0, 3844);
    chk("s2_fd_count", n_fd - f0, 1);
    chk("s2_first_win", cap_win, 72'h82_81_80_42_41_40_02_01_00);
    chk("s2_first_row", cap_row, 7'd1);
    chk("s2_first_col", cap_col, 7'd1);
    chk("s2_last_p8", last_win[71:64], 8'd255);
    chk("s2_last_row", last_row, 7'd62);
    chk("s2_last_col", last_col, 7'd62);

    // Ramp with random 50% in_valid duty.
    v0 = n_valid; f0 = n_fd;
    run_pixels(W * H, 1'b0, 1'b1, 1'b1);
    drain();
    chk("s4_count", n_valid - v0, 3844);
    chk("s4_fd_count", n_fd - f0, 1);
    chk("s4_first_win", cap_win, 72'h82_81_80_42_41_40_02_01_00);

    // Reset after 1000 pixels, then a full frame.
    run_pixels(1000, 1'b0, 1'b0, 1'b0);
    drain();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'h5A;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    br = 0; bc = 0;
    @(negedge clk);
    chk("s5_rst_valid", out_valid, 1'b0);
    v0 = n_valid; f0 = n_fd;
    run_pixels(W * H, 1'b0, 1'b0, 1'b1);
    drain();
    chk("s5_count", n_valid - v0, 3844);
    chk("s5_fd_count", n_fd - f0, 1);
    chk("s5_first_row", cap_row, 7'd1);
    chk("s5_first_col", cap_col, 7'd1);

    // Back-to-back frames: ramp then inverted ramp, no gap.
    v0 = n_valid; f0 = n_fd;
    run_pixels(W * H, 1'b0, 1'b0, 1'b0);
    run_pixels(W * H, 1'b1, 1'b0, 1'b1);
    drain();
    chk("s6_count", n_valid - v0, 7688);
    chk("s6_fd_count", n_fd - f0, 2);
    chk("s6_first_row", cap_row, 7'd1);
    chk("s6_first_col", cap_col, 7'd1);
    chk("s6_first_p0", cap_win[7:0], 8'd255);
    chk("s6_first_p4", cap_win[39:32], 8'd190);
    chk("s6_first_p8", cap_win[71:64], 8'd125);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
